// File: rtl/ex_mem_stage_if.sv
// Execute-to-memory handshake and payload bundle for ex_mem_stage.
// slave: the stage itself (consumes execute side, drives memory side).
// master: the surrounding pipeline (drives execute side, consumes memory side).
interface ex_mem_stage_if #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 32
) ();
    // Execute side
    logic              ex_valid_i;
    logic              ex_ready_o;
    logic [AWIDTH-1:0] pc_i;
    logic [DWIDTH-1:0] res_i;
    logic [DWIDTH-1:0] rs2_i;
    logic [4:0]        rd_i;
    logic [6:0]        opcode_i;
    logic [2:0]        funct3_i;
    logic              regwren_i;
    logic              brtaken_i;
    // Memory side
    logic              mem_valid_o;
    logic              mem_ready_i;
    logic [AWIDTH-1:0] mem_pc_o;
    logic [DWIDTH-1:0] mem_alu_o;
    logic [DWIDTH-1:0] mem_data_o;
    logic [4:0]        mem_rd_o;
    logic [6:0]        mem_opcode_o;
    logic [2:0]        mem_funct3_o;
    logic              mem_regwren_o;

    modport slave (
        input  ex_valid_i, pc_i, res_i, rs2_i, rd_i, opcode_i, funct3_i,
               regwren_i, brtaken_i, mem_ready_i,
        output ex_ready_o, mem_valid_o, mem_pc_o, mem_alu_o, mem_data_o,
               mem_rd_o, mem_opcode_o, mem_funct3_o, mem_regwren_o
    );

    modport master (
        output ex_valid_i, pc_i, res_i, rs2_i, rd_i, opcode_i, funct3_i,
               regwren_i, brtaken_i, mem_ready_i,
        input  ex_ready_o, mem_valid_o, mem_pc_o, mem_alu_o, mem_data_o,
               mem_rd_o, mem_opcode_o, mem_funct3_o, mem_regwren_o
    );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: 2-entry skid buffer toward memory, registered PC
// redirect for taken control flow, link-value substitution for JAL/JALR and
// squashing of the wrong-path instructions accepted after a redirect.
// Optional build macro EXMEM_MISALIGN_CHECK_EN adds misalign_o and suppresses
// redirects to targets that are not 4-byte aligned.
module ex_mem_stage #(
    parameter int unsigned DWIDTH       = 32,
    parameter int unsigned AWIDTH       = 32,
    parameter int unsigned SQUASH_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    ex_mem_stage_if.slave     bus,
    output logic              redirect_o,
    output logic [AWIDTH-1:0] redirect_pc_o
`ifdef EXMEM_MISALIGN_CHECK_EN
    ,
    output logic              misalign_o
`endif
);

    localparam int unsigned CNT_W = 3;

    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

    typedef struct packed {
        logic [AWIDTH-1:0] pc;
        logic [DWIDTH-1:0] alu;
        logic [DWIDTH-1:0] data;
        logic [4:0]        rd;
        logic [6:0]        opcode;
        logic [2:0]        funct3;
        logic              regwren;
    } entry_t;

    entry_t            r_main;
    entry_t            r_skid;
    logic              r_main_valid;
    logic              r_skid_valid;
    logic [CNT_W-1:0]  r_sq_cnt;
    logic              r_redirect;
    logic [AWIDTH-1:0] r_redirect_pc;

    logic   w_accept;
    logic   w_keep;
    logic   w_fire;
    logic   w_is_jump;
    logic   w_is_cf;
    logic   w_trigger;
    logic   w_misalign;
    entry_t w_entry;

    // Handshake decode; ready depends only on registered skid occupancy
    assign bus.ex_ready_o  = !r_skid_valid;
    assign w_accept        = bus.ex_valid_i && !r_skid_valid;
    assign w_keep          = w_accept && (r_sq_cnt == '0);
    assign w_fire          = r_main_valid && bus.mem_ready_i;

    assign w_is_jump = (bus.opcode_i == OPCODE_JAL) || (bus.opcode_i == OPCODE_JALR);
    assign w_is_cf   = w_is_jump || (bus.opcode_i == OPCODE_BRANCH);
    assign w_trigger = w_keep && bus.brtaken_i && w_is_cf;

`ifdef EXMEM_MISALIGN_CHECK_EN
    assign w_misalign = w_trigger && (bus.res_i[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // Entry as it will be stored: link value for jumps, write enable killed on misaligned target
    always_comb begin
        w_entry         = '0;
        w_entry.pc      = bus.pc_i;
        w_entry.alu     = w_is_jump ? DWIDTH'(bus.pc_i + AWIDTH'(4)) : bus.res_i;
        w_entry.data    = bus.rs2_i;
        w_entry.rd      = bus.rd_i;
        w_entry.opcode  = bus.opcode_i;
        w_entry.funct3  = bus.funct3_i;
        w_entry.regwren = bus.regwren_i && !w_misalign;
    end

    // Skid buffer: main feeds memory, skid catches the one entry accepted while main is stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid || w_fire) begin
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_keep) begin
                r_main       <= w_entry;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_keep) begin
            r_skid       <= w_entry;
            r_skid_valid <= 1'b1;
        end
    end

    // Squash counter: reload on redirect, count down only on accepted (dropped) entries
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sq_cnt <= '0;
        end else if (w_trigger) begin
            r_sq_cnt <= CNT_W'(SQUASH_DEPTH);
        end else if (w_accept && (r_sq_cnt != '0)) begin
            r_sq_cnt <= r_sq_cnt - CNT_W'(1);
        end
    end

    // One-cycle redirect pulse; target held until the next redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_redirect <= w_trigger && !w_misalign;
            if (w_trigger && !w_misalign) begin
                r_redirect_pc <= AWIDTH'(bus.res_i);
            end
        end
    end

`ifdef EXMEM_MISALIGN_CHECK_EN
    logic r_misalign;

    // Misaligned-target flag pulses in place of the suppressed redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misalign;
        end
    end

    assign misalign_o = r_misalign;
`endif

    assign redirect_o        = r_redirect;
    assign redirect_pc_o     = r_redirect_pc;
    assign bus.mem_valid_o   = r_main_valid;
    assign bus.mem_pc_o      = r_main.pc;
    assign bus.mem_alu_o     = r_main.alu;
    assign bus.mem_data_o    = r_main.data;
    assign bus.mem_rd_o      = r_main.rd;
    assign bus.mem_opcode_o  = r_main.opcode;
    assign bus.mem_funct3_o  = r_main.funct3;
    assign bus.mem_regwren_o = r_main.regwren;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: a vector table for backpressure, jump
// squash and branch cases, plus hand-written multi-cycle sequences.
module tb_ex_mem_stage;

    localparam logic [6:0] OP_ALU   = 7'b0110011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    logic        clk;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef EXMEM_MISALIGN_CHECK_EN
    logic        misalign;
`endif

    int n_chk;
    int n_pass;

    ex_mem_stage_if #(.DWIDTH(32), .AWIDTH(32)) bus_if ();

    ex_mem_stage #(.DWIDTH(32), .AWIDTH(32), .SQUASH_DEPTH(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus_if),
        .redirect_o    (redirect),
        .redirect_pc_o (redirect_pc)
`ifdef EXMEM_MISALIGN_CHECK_EN
        ,
        .misalign_o    (misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic        mr;
        logic [31:0] pc;
        logic [31:0] res;
        logic [6:0]  op;
        logic        tk;
        logic        wr;
        logic        e_rdy;
        logic        e_mv;
        logic [31:0] e_pc;
        logic [31:0] e_alu;
        logic        e_wr;
        logic        e_rd;
        logic [31:0] e_rpc;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic vld, input logic mr, input logic [31:0] pc,
                         input logic [31:0] res, input logic [6:0] op, input logic tk,
                         input logic wr, input logic [31:0] rs2, input logic [4:0] rd,
                         input logic [2:0] f3);
        bus_if.ex_valid_i  = vld;
        bus_if.mem_ready_i = mr;
        bus_if.pc_i        = pc;
        bus_if.res_i       = res;
        bus_if.opcode_i    = op;
        bus_if.brtaken_i   = tk;
        bus_if.regwren_i   = wr;
        bus_if.rs2_i       = rs2;
        bus_if.rd_i        = rd;
        bus_if.funct3_i    = f3;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic vld, input logic mr, input logic [31:0] pc,
                                input logic [31:0] res, input logic [6:0] op, input logic tk,
                                input logic wr, input logic e_rdy, input logic e_mv,
                                input logic [31:0] e_pc, input logic [31:0] e_alu,
                                input logic e_wr, input logic e_rd, input logic [31:0] e_rpc);
        vec_t v;
        v.vld = vld; v.mr = mr; v.pc = pc; v.res = res; v.op = op; v.tk = tk; v.wr = wr;
        v.e_rdy = e_rdy; v.e_mv = e_mv; v.e_pc = e_pc; v.e_alu = e_alu;
        v.e_wr = e_wr; v.e_rd = e_rd; v.e_rpc = e_rpc;
        return v;
    endfunction

    initial begin
        n_chk  = 0;
        n_pass = 0;

        //             vld mr  pc     res    op      tk wr | rdy mv  pc     alu    wr rd rpc
        vecs[0]  = mk(1, 0, 32'h0,   32'h10,  OP_ALU, 0, 1,  1, 1, 32'h0,   32'h10,  1, 0, 32'h0);
        vecs[1]  = mk(1, 0, 32'h4,   32'h20,  OP_ALU, 0, 1,  0, 1, 32'h0,   32'h10,  1, 0, 32'h0);
        vecs[2]  = mk(1, 0, 32'h8,   32'h30,  OP_ALU, 0, 1,  0, 1, 32'h0,   32'h10,  1, 0, 32'h0);
        vecs[3]  = mk(1, 1, 32'h8,   32'h30,  OP_ALU, 0, 1,  1, 1, 32'h4,   32'h20,  1, 0, 32'h0);
        vecs[4]  = mk(1, 0, 32'h8,   32'h30,  OP_ALU, 0, 1,  0, 1, 32'h4,   32'h20,  1, 0, 32'h0);
        vecs[5]  = mk(0, 1, 32'h0,   32'h0,   OP_ALU, 0, 0,  1, 1, 32'h8,   32'h30,  1, 0, 32'h0);
        vecs[6]  = mk(0, 1, 32'h0,   32'h0,   OP_ALU, 0, 0,  1, 0, 32'h0,   32'h0,   0, 0, 32'h0);
        vecs[7]  = mk(1, 1, 32'h100, 32'h200, OP_JAL, 1, 1,  1, 1, 32'h100, 32'h104, 1, 1, 32'h200);
        vecs[8]  = mk(1, 1, 32'h104, 32'h999, OP_ALU, 0, 1,  1, 0, 32'h0,   32'h0,   0, 0, 32'h200);
        vecs[9]  = mk(1, 1, 32'h108, 32'hAAA, OP_ALU, 0, 1,  1, 0, 32'h0,   32'h0,   0, 0, 32'h200);
        vecs[10] = mk(1, 1, 32'h200, 32'h55,  OP_ALU, 0, 1,  1, 1, 32'h200, 32'h55,  1, 0, 32'h200);
        vecs[11] = mk(1, 1, 32'h204, 32'h80,  OP_BR,  0, 0,  1, 1, 32'h204, 32'h80,  0, 0, 32'h200);
        vecs[12] = mk(1, 1, 32'h208, 32'h11,  OP_ALU, 0, 1,  1, 1, 32'h208, 32'h11,  1, 0, 32'h200);
        vecs[13] = mk(1, 1, 32'h20c, 32'h300, OP_ALU, 1, 1,  1, 1, 32'h20c, 32'h300, 1, 0, 32'h200);
        vecs[14] = mk(1, 1, 32'h210, 32'h22,  OP_ALU, 0, 1,  1, 1, 32'h210, 32'h22,  1, 0, 32'h200);
        vecs[15] = mk(0, 1, 32'h0,   32'h0,   OP_ALU, 0, 0,  1, 0, 32'h0,   32'h0,   0, 0, 32'h200);

        // Reset and check reset state
        reset = 1'b1;
        drive(0, 0, 0, 0, OP_ALU, 0, 0, 0, 0, 0);
        step();
        step();
        chk("rst_mem_valid", 32'(bus_if.mem_valid_o), 32'd0);
        chk("rst_ex_ready", 32'(bus_if.ex_ready_o), 32'd1);
        chk("rst_redirect", 32'(redirect), 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'h0);
        chk("rst_mem_alu", bus_if.mem_alu_o, 32'h0);
        chk("rst_mem_pc", bus_if.mem_pc_o, 32'h0);
        reset = 1'b0;

        // Table: backpressure ordering, JAL link + squash, not-taken branch, ignored brtaken
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].vld, vecs[i].mr, vecs[i].pc, vecs[i].res, vecs[i].op,
                  vecs[i].tk, vecs[i].wr, 32'h0, 5'd1, 3'd0);
            step();
            chk($sformatf("v%0d_ex_ready", i), 32'(bus_if.ex_ready_o), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d_mem_valid", i), 32'(bus_if.mem_valid_o), 32'(vecs[i].e_mv));
            chk($sformatf("v%0d_redirect", i), 32'(redirect), 32'(vecs[i].e_rd));
            chk($sformatf("v%0d_redirect_pc", i), redirect_pc, vecs[i].e_rpc);
            if (vecs[i].e_mv) begin
                chk($sformatf("v%0d_mem_pc", i), bus_if.mem_pc_o, vecs[i].e_pc);
                chk($sformatf("v%0d_mem_alu", i), bus_if.mem_alu_o, vecs[i].e_alu);
                chk($sformatf("v%0d_mem_regwren", i), 32'(bus_if.mem_regwren_o), 32'(vecs[i].e_wr));
            end
        end

        // Taken BNE accepted while squash counter is 1: dropped, no redirect
        drive(1, 1, 32'h300, 32'h400, OP_JAL, 1, 1, 0, 5'd1, 3'd0);
        step();
        chk("bne_jal_redirect", 32'(redirect), 32'd1);
        chk("bne_jal_rpc", redirect_pc, 32'h400);
        chk("bne_jal_link", bus_if.mem_alu_o, 32'h304);
        drive(1, 1, 32'h304, 32'h1, OP_ALU, 0, 1, 0, 5'd1, 3'd0);
        step();
        chk("bne_drop1_valid", 32'(bus_if.mem_valid_o), 32'd0);
        drive(1, 1, 32'h308, 32'h500, OP_BR, 1, 0, 0, 5'd0, 3'd1);
        step();
        chk("bne_drop2_valid", 32'(bus_if.mem_valid_o), 32'd0);
        chk("bne_no_redirect", 32'(redirect), 32'd0);
        chk("bne_rpc_hold", redirect_pc, 32'h400);
        drive(1, 1, 32'h400, 32'h77, OP_ALU, 0, 1, 0, 5'd1, 3'd0);
        step();
        chk("bne_after_redirect", 32'(redirect), 32'd0);
        chk("bne_after_valid", 32'(bus_if.mem_valid_o), 32'd1);
        chk("bne_after_alu", bus_if.mem_alu_o, 32'h77);

        // Store payload passthrough
        drive(1, 1, 32'h410, 32'h1000, OP_STORE, 0, 0, 32'hDEADBEEF, 5'd7, 3'd2);
        step();
        chk("st_alu", bus_if.mem_alu_o, 32'h1000);
        chk("st_data", bus_if.mem_data_o, 32'hDEADBEEF);
        chk("st_rd", 32'(bus_if.mem_rd_o), 32'd7);
        chk("st_funct3", 32'(bus_if.mem_funct3_o), 32'd2);
        chk("st_opcode", 32'(bus_if.mem_opcode_o), 32'(OP_STORE));
        chk("st_regwren", 32'(bus_if.mem_regwren_o), 32'd0);

        // JALR to 0x202: misaligned when the check is built in, otherwise a normal redirect
        drive(1, 1, 32'h600, 32'h202, OP_JALR, 1, 1, 0, 5'd1, 3'd0);
        step();
        chk("jalr_link", bus_if.mem_alu_o, 32'h604);
`ifdef EXMEM_MISALIGN_CHECK_EN
        chk("jalr_misalign", 32'(misalign), 32'd1);
        chk("jalr_redirect", 32'(redirect), 32'd0);
        chk("jalr_regwren", 32'(bus_if.mem_regwren_o), 32'd0);
        chk("jalr_rpc_hold", redirect_pc, 32'h400);
`else
        chk("jalr_redirect", 32'(redirect), 32'd1);
        chk("jalr_rpc", redirect_pc, 32'h202);
        chk("jalr_regwren", 32'(bus_if.mem_regwren_o), 32'd1);
`endif
        drive(1, 1, 32'h604, 32'h2, OP_ALU, 0, 1, 0, 5'd1, 3'd0);
        step();
        chk("jalr_drop1", 32'(bus_if.mem_valid_o), 32'd0);
        chk("jalr_pulse_end", 32'(redirect), 32'd0);
`ifdef EXMEM_MISALIGN_CHECK_EN
        chk("jalr_misalign_end", 32'(misalign), 32'd0);
`endif
        drive(1, 1, 32'h608, 32'h3, OP_ALU, 0, 1, 0, 5'd1, 3'd0);
        step();
        chk("jalr_drop2", 32'(bus_if.mem_valid_o), 32'd0);

        // Reset mid-stream with both entries full and squash counter loaded
        drive(1, 0, 32'h40, 32'h44, OP_ALU, 0, 1, 0, 5'd1, 3'd0);
        step();
        chk("mid_main_valid", 32'(bus_if.mem_valid_o), 32'd1);
        drive(1, 0, 32'h44, 32'h80, OP_JAL, 1, 1, 0, 5'd1, 3'd0);
        step();
        chk("mid_full_ready", 32'(bus_if.ex_ready_o), 32'd0);
        chk("mid_full_redirect", 32'(redirect), 32'd1);
        reset = 1'b1;
        drive(1, 1, 32'h48, 32'h5, OP_ALU, 0, 1, 0, 5'd1, 3'd0);
        step();
        chk("mid_rst_valid", 32'(bus_if.mem_valid_o), 32'd0);
        chk("mid_rst_ready", 32'(bus_if.ex_ready_o), 32'd1);
        chk("mid_rst_redirect", 32'(redirect), 32'd0);
        chk("mid_rst_rpc", redirect_pc, 32'h0);
        chk("mid_rst_alu", bus_if.mem_alu_o, 32'h0);
        reset = 1'b0;
        drive(1, 1, 32'h50, 32'h66, OP_ALU, 0, 1, 0, 5'd1, 3'd0);
        step();
        chk("post_rst_valid", 32'(bus_if.mem_valid_o), 32'd1);
        chk("post_rst_alu", bus_if.mem_alu_o, 32'h66);
        chk("post_rst_pc", bus_if.mem_pc_o, 32'h50);

        drive(0, 1, 0, 0, OP_ALU, 0, 0, 0, 0, 0);
        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
